// File: rtl/pet_mood_fsm.sv
// Debounced pet mood resolver: turns four clamped need levels into one committed
// mood, a change strobe and a registered alert, evaluated only on tick cycles.
module pet_mood_fsm #(
  parameter int PERSIST   = 3,
  parameter int SICK_TIME = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic [2:0] nh,
  input  logic [2:0] ns,
  input  logic [2:0] nf,
  input  logic [2:0] ne,
  output logic [2:0] mood,
  output logic       mood_chg,
  output logic       alert
);

  localparam int CMAX = (PERSIST > SICK_TIME) ? PERSIST : SICK_TIME;
  localparam int CW   = $clog2(CMAX + 1);

  localparam logic [CW-1:0] SICK_C    = CW'(SICK_TIME);
  localparam logic [CW:0]   PERSIST_W = (CW+1)'(PERSIST);

  typedef enum logic [2:0] {
    HAPPY   = 3'd0,
    NEUTRAL = 3'd1,
    HUNGRY  = 3'd2,
    TIRED   = 3'd3,
    SLEEPY  = 3'd4,
    BORED   = 3'd5,
    SICK    = 3'd6
  } mood_e;

  mood_e         mood_q, mood_d;
  mood_e         pend_q, pend_d;
  mood_e         cand;
  logic [CW-1:0] pcnt_q, pcnt_d;
  logic [CW-1:0] scnt_q, scnt_d;
  logic          chg_d, alert_d;

  logic [2:0] lh, ls, lf, le;
  logic [2:0] crit;
  logic       all_ge3, all_ge4;
  logic       persist_done;
  logic       sick_hit;

  function automatic logic [2:0] clamp(input logic [2:0] v);
    if (v == 3'd0)     return 3'd1;
    else if (v > 3'd5) return 3'd5;
    else               return v;
  endfunction

  assign lh = clamp(nh);
  assign ls = clamp(ns);
  assign lf = clamp(nf);
  assign le = clamp(ne);

  assign crit = 3'(lh == 3'd1) + 3'(ls == 3'd1) + 3'(lf == 3'd1) + 3'(le == 3'd1);

  assign all_ge3 = (lh >= 3'd3) && (ls >= 3'd3) && (lf >= 3'd3) && (le >= 3'd3);
  assign all_ge4 = (lh >= 3'd4) && (ls >= 3'd4) && (lf >= 3'd4) && (le >= 3'd4);

  // Priority order matters: a starving pet reads as HUNGRY even when also exhausted.
  always_comb begin
    cand = NEUTRAL;
    if      (lh <= 3'd2) cand = HUNGRY;
    else if (le <= 3'd2) cand = TIRED;
    else if (ls <= 3'd2) cand = SLEEPY;
    else if (lf <= 3'd2) cand = BORED;
    else if (all_ge4)    cand = HAPPY;
  end

  // Extra bit so pcnt+1 cannot wrap before the comparison.
  assign persist_done = ({1'b0, pcnt_q} + (CW+1)'(1)) >= PERSIST_W;
  assign sick_hit     = (crit >= 3'd2) && (scnt_q == SICK_C - CW'(1));

  // NOTE: every variable written here gets a default first, so no path can leave
  // one unassigned and infer a latch.
  always_comb begin
    mood_d = mood_q;
    pend_d = pend_q;
    pcnt_d = pcnt_q;
    scnt_d = scnt_q;
    if (tick) begin
      if (crit >= 3'd2) scnt_d = (scnt_q == SICK_C) ? scnt_q : scnt_q + CW'(1);
      else              scnt_d = '0;

      if (mood_q != SICK) begin
        if (sick_hit) begin
          mood_d = SICK;
          pcnt_d = '0;
        end else if (cand == mood_q) begin
          pcnt_d = '0;
        end else if (cand == pend_q) begin
          if (persist_done) begin
            mood_d = cand;
            pcnt_d = '0;
          end else begin
            pcnt_d = pcnt_q + CW'(1);
          end
        end else begin
          pend_d = cand;
          if (PERSIST == 1) begin
            mood_d = cand;
            pcnt_d = '0;
          end else begin
            pcnt_d = CW'(1);
          end
        end
      end else begin
        if (all_ge3) begin
          if (persist_done) begin
            mood_d = cand;
            pend_d = cand;
            pcnt_d = '0;
            scnt_d = '0;
          end else begin
            pcnt_d = pcnt_q + CW'(1);
          end
        end else begin
          pcnt_d = '0;
        end
      end
    end
    chg_d   = (mood_d != mood_q);
    alert_d = (mood_q == SICK) || (crit != 3'd0);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mood_q   <= NEUTRAL;
      pend_q   <= NEUTRAL;
      pcnt_q   <= '0;
      scnt_q   <= '0;
      mood_chg <= 1'b0;
      alert    <= 1'b0;
    end else begin
      mood_q   <= mood_d;
      pend_q   <= pend_d;
      pcnt_q   <= pcnt_d;
      scnt_q   <= scnt_d;
      mood_chg <= chg_d;
      alert    <= alert_d;
    end
  end

  assign mood = mood_q;

endmodule

// File: tb/tb_pet_mood_fsm.sv
// Self-checking bench for pet_mood_fsm: a rule-level mood model compared every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_pet_mood_fsm;

  localparam int P  = 3;
  localparam int ST = 10;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick;
  logic [2:0] nh, ns, nf, ne;
  logic [2:0] mood;
  logic       mood_chg;
  logic       alert;

  int checks   = 0;
  int errors   = 0;
  int chg_seen = 0;

  always #5 clk = ~clk;

  pet_mood_fsm #(.PERSIST(P), .SICK_TIME(ST)) dut (
    .clk      (clk),
    .rst      (rst),
    .tick     (tick),
    .nh       (nh),
    .ns       (ns),
    .nf       (nf),
    .ne       (ne),
    .mood     (mood),
    .mood_chg (mood_chg),
    .alert    (alert)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_mood = 1, m_pend = 1, m_pcnt = 0, m_scnt = 0;
  bit m_chg = 1'b0, m_alert = 1'b0;

  function automatic int clampv(input int v);
    return (v < 1) ? 1 : ((v > 5) ? 5 : v);
  endfunction

  always @(posedge clk or posedge rst) begin : model
    int lv[4];
    int need_mood[4];
    int cand, crit, old, lo, nscnt;
    if (rst) begin
      m_mood = 1; m_pend = 1; m_pcnt = 0; m_scnt = 0; m_chg = 0; m_alert = 0;
    end else begin
      // order of priority: hunger, energy, sleep, fun
      lv[0] = clampv(int'(nh)); lv[1] = clampv(int'(ne));
      lv[2] = clampv(int'(ns)); lv[3] = clampv(int'(nf));
      need_mood[0] = 2; need_mood[1] = 3; need_mood[2] = 4; need_mood[3] = 5;
      crit = 0; lo = 5; cand = -1;
      for (int i = 0; i < 4; i++) begin
        if (lv[i] == 1) crit++;
        if (lv[i] < lo) lo = lv[i];
        if (cand < 0 && lv[i] <= 2) cand = need_mood[i];
      end
      if (cand < 0) cand = (lo >= 4) ? 0 : 1;
      old = m_mood;
      m_alert = (old == 6) || (crit > 0);
      if (tick) begin
        nscnt = (crit >= 2) ? ((m_scnt + 1 > ST) ? ST : m_scnt + 1) : 0;
        if (old != 6) begin
          if (nscnt == ST && m_scnt < ST) begin
            m_mood = 6; m_pcnt = 0;
          end else if (cand == old) begin
            m_pcnt = 0;
          end else if (cand == m_pend) begin
            m_pcnt++;
            if (m_pcnt >= P) begin m_mood = cand; m_pcnt = 0; end
          end else begin
            m_pend = cand; m_pcnt = 1;
            if (P == 1) begin m_mood = cand; m_pcnt = 0; end
          end
        end else if (lo >= 3) begin
          m_pcnt++;
          if (m_pcnt >= P) begin
            m_mood = cand; m_pend = cand; m_pcnt = 0; nscnt = 0;
          end
        end else begin
          m_pcnt = 0;
        end
        m_scnt = nscnt;
      end
      m_chg = (m_mood != old);
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (!rst) begin
      check("model_mood", 32'(mood), 32'(m_mood));
      check("model_mood_chg", 32'(mood_chg), 32'(m_chg));
      check("model_alert", 32'(alert), 32'(m_alert));
      if (mood_chg === 1'b1) chg_seen++;
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic set_lv(input int h, input int s, input int f, input int e);
    nh = 3'(h); ns = 3'(s); nf = 3'(f); ne = 3'(e);
  endtask

  task automatic tick_n(input int n);
    repeat (n) begin
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
      @(negedge clk);
    end
  endtask

  initial begin
    rst  = 1'b1;
    tick = 1'b0;
    set_lv(3, 3, 3, 3);
    repeat (2) @(negedge clk);
    check("reset_mood", 32'(mood), 32'd1);
    check("reset_alert", 32'(alert), 32'd0);
    check("reset_chg", 32'(mood_chg), 32'd0);
    rst = 1'b0;

    // neutral levels hold NEUTRAL
    tick_n(5);
    check("neutral_mood", 32'(mood), 32'd1);
    check("neutral_alert", 32'(alert), 32'd0);
    check("neutral_no_pulse", 32'(chg_seen), 32'd0);

    // all 5 -> HAPPY on 3rd tick
    set_lv(5, 5, 5, 5);
    tick_n(2);
    check("happy_before", 32'(mood), 32'd1);
    tick_n(1);
    check("happy_commit", 32'(mood), 32'd0);
    check("happy_one_pulse", 32'(chg_seen), 32'd1);

    // interrupted HUNGRY episode, then committed one
    set_lv(2, 5, 5, 5);
    tick_n(2);
    check("hungry_ep1", 32'(mood), 32'd0);
    set_lv(5, 5, 5, 5);
    tick_n(1);
    check("hungry_gap", 32'(mood), 32'd0);
    set_lv(2, 5, 5, 5);
    tick_n(2);
    check("hungry_ep2_t2", 32'(mood), 32'd0);
    tick_n(1);
    check("hungry_ep2_t3", 32'(mood), 32'd2);

    // hunger outranks low energy
    set_lv(2, 5, 5, 1);
    tick_n(3);
    check("hunger_priority", 32'(mood), 32'd2);
    check("crit1_alert", 32'(alert), 32'd1);

    set_lv(5, 5, 5, 5);
    tick_n(3);
    check("back_happy", 32'(mood), 32'd0);
    check("back_alert", 32'(alert), 32'd0);

    // sick counting broken by a crit=1 tick on tick 9
    set_lv(1, 5, 5, 1);
    @(negedge clk);
    check("alert_latency", 32'(alert), 32'd1);
    tick_n(8);
    check("pre_break_mood", 32'(mood), 32'd2);
    set_lv(1, 5, 5, 5);
    tick_n(1);
    check("break_no_sick", 32'(mood), 32'd2);
    check("break_scnt", 32'(dut.scnt_q), 32'd0);
    set_lv(1, 5, 5, 1);
    tick_n(9);
    check("sick_tick9", 32'(mood), 32'd2);
    tick_n(1);
    check("sick_tick10", 32'(mood), 32'd6);
    check("sick_alert", 32'(alert), 32'd1);

    // recovery from SICK
    set_lv(4, 4, 4, 4);
    tick_n(2);
    check("recover_hold", 32'(mood), 32'd6);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    check("recover_mood", 32'(mood), 32'd0);
    check("recover_pulse", 32'(mood_chg), 32'd1);
    check("recover_alert_lag", 32'(alert), 32'd1);
    @(negedge clk);
    check("recover_alert_clr", 32'(alert), 32'd0);
    check("recover_pulse_end", 32'(mood_chg), 32'd0);

    // out-of-range clamp plus reset mid-persistence with tick high
    set_lv(0, 5, 7, 5);
    @(negedge clk);
    check("clamp_alert", 32'(alert), 32'd1);
    tick_n(2);
    check("clamp_pending", 32'(mood), 32'd0);
    tick = 1'b1;
    rst  = 1'b1;
    #1;
    check("rst_mood", 32'(mood), 32'd1);
    check("rst_pcnt", 32'(dut.pcnt_q), 32'd0);
    check("rst_scnt", 32'(dut.scnt_q), 32'd0);
    check("rst_pend", 32'(dut.pend_q), 32'd1);
    check("rst_alert", 32'(alert), 32'd0);
    @(negedge clk);
    check("rst_tick_ignored", 32'(mood), 32'd1);
    rst  = 1'b0;
    tick = 1'b0;
    tick_n(2);
    check("restart_t2", 32'(mood), 32'd1);
    tick_n(1);
    check("clamp_hungry", 32'(mood), 32'd2);

    // levels 6 clamp to 5 -> HAPPY
    set_lv(6, 6, 6, 6);
    tick_n(3);
    check("clamp_happy", 32'(mood), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
